// File: rtl/bus_if.sv
// Per-stage memory access initiator: routes CPU word accesses to the owned SPM port
// (zero stall) or to the shared system bus through request/grant/strobe/ready sequencing.
module bus_if #(
  parameter int              WORD_ADDR_W = 30,
  parameter int              DATA_W      = 32,
  parameter int              SPM_ADDR_W  = 12,
  parameter logic [2:0]      SPM_AREA    = 3'h3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic [SPM_ADDR_W-1:0]  spm_addr,
  output logic                   spm_as_,
  output logic                   spm_rw,
  output logic [DATA_W-1:0]      spm_wr_data,
  input  logic [DATA_W-1:0]      spm_rd_data,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [DATA_W-1:0]      bus_wr_data,
  input  logic [DATA_W-1:0]      bus_rd_data,
  input  logic                   bus_rdy_
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t            state;
  logic [DATA_W-1:0] rd_buf;
  logic              spm_hit;
  logic              access;

  assign spm_hit     = (addr[WORD_ADDR_W-1 -: 3] == SPM_AREA);
  assign access      = !flush && !as_;
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  // Pipeline-facing outputs are combinational so SPM hits and bus completion cost no extra cycle.
  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    spm_as_ = 1'b1;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (spm_hit) begin
              spm_as_ = 1'b0;
              rd_data = spm_rd_data;
            end else begin
              busy = 1'b1;
            end
          end
        end
        REQ:    busy = 1'b1;
        ACCESS: begin
          if (!bus_rdy_) rd_data = bus_rd_data;
          else           busy    = 1'b1;
        end
        STALL:  rd_data = rd_buf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !spm_hit) begin
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
            bus_req_    <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            bus_as_ <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            bus_req_    <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= 1'b1;
            bus_wr_data <= '0;
            rd_buf      <= bus_rd_data;
            state       <= stall ? STALL : IDLE;
          end
        end
        STALL: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed bench for bus_if: SPM hit, bus read/write with wait states, stall buffering,
// flush handling and asynchronous reset mid-transaction.
module tb_bus_if;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy;
  logic [29:0] addr;
  logic        as_, rw;
  logic [31:0] wr_data, rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data, spm_rd_data;
  logic        bus_req_, bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_rdy_;

  int n_cmp = 0;
  int n_bad = 0;
  int as_cnt = 0;
  int as_base;

  bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  // counts cycles in which the bus strobe is active
  always @(negedge clk) if (!bus_as_) as_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1; rw = 1'b1;
    wr_data = '0; spm_rd_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
    step; step;
    reset = 1'b0;
    settle;
    chk("rst_busy", busy, 0);
    chk("rst_req", bus_req_, 1);
    chk("rst_as", bus_as_, 1);
    chk("rst_rw", bus_rw, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wr_data, 0);
    chk("rst_spm_as", spm_as_, 1);
    chk("rst_rd_data", rd_data, 0);

    // SPM read
    addr = 30'h1800_0010; as_ = 1'b0; rw = 1'b1; wr_data = 32'h0F0F_1111;
    spm_rd_data = 32'hCAFE_0001;
    settle;
    chk("spm_as", spm_as_, 0);
    chk("spm_addr", spm_addr, 12'h010);
    chk("spm_rw", spm_rw, 1);
    chk("spm_wdata", spm_wr_data, 32'h0F0F_1111);
    chk("spm_rd_data", rd_data, 32'hCAFE_0001);
    chk("spm_busy", busy, 0);
    step;
    chk("spm_no_req", bus_req_, 1);
    chk("spm_busy2", busy, 0);

    // bus read, immediate grant, device ready the cycle after the strobe
    as_ = 1'b1; settle;
    chk("idle_spm_as", spm_as_, 1);
    addr = 30'h0000_0040; as_ = 1'b0; rw = 1'b1;
    settle;
    chk("rd_c0_busy", busy, 1);
    chk("rd_c0_req", bus_req_, 1);
    chk("rd_c0_spm_as", spm_as_, 1);
    step;
    bus_grnt_ = 1'b0; settle;
    chk("rd_c1_req", bus_req_, 0);
    chk("rd_c1_busy", busy, 1);
    chk("rd_c1_as", bus_as_, 1);
    step;
    chk("rd_c2_as", bus_as_, 0);
    chk("rd_c2_addr", bus_addr, 30'h40);
    chk("rd_c2_rw", bus_rw, 1);
    chk("rd_c2_busy", busy, 1);
    bus_grnt_ = 1'b1;
    step;
    chk("rd_c3_as", bus_as_, 1);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h1234_5678; settle;
    chk("rd_c3_busy", busy, 0);
    chk("rd_c3_data", rd_data, 32'h1234_5678);
    as_ = 1'b1;
    step;
    bus_rdy_ = 1'b1; settle;
    chk("rd_c4_req", bus_req_, 1);
    chk("rd_c4_addr", bus_addr, 0);
    chk("rd_c4_busy", busy, 0);
    chk("rd_c4_data", rd_data, 0);

    // bus write, grant after 4 cycles, ready after 2 wait cycles
    as_base = as_cnt;
    addr = 30'h0000_1234; rw = 1'b0; wr_data = 32'hA5A5_A5A5; as_ = 1'b0;
    settle;
    chk("wr_c0_busy", busy, 1);
    step;
    for (int i = 0; i < 4; i++) begin
      chk("wr_req_busy", busy, 1);
      chk("wr_req_req", bus_req_, 0);
      chk("wr_req_as", bus_as_, 1);
      chk("wr_req_rw", bus_rw, 0);
      chk("wr_req_wdata", bus_wr_data, 32'hA5A5_A5A5);
      step;
    end
    bus_grnt_ = 1'b0; settle;
    chk("wr_grant_busy", busy, 1);
    step;
    bus_grnt_ = 1'b1;
    chk("wr_a0_as", bus_as_, 0);
    chk("wr_a0_busy", busy, 1);
    chk("wr_a0_addr", bus_addr, 30'h1234);
    step;
    chk("wr_a1_as", bus_as_, 1);
    chk("wr_a1_busy", busy, 1);
    chk("wr_a1_wdata", bus_wr_data, 32'hA5A5_A5A5);
    step;
    chk("wr_a2_busy", busy, 1);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF; settle;
    chk("wr_rdy_busy", busy, 0);
    chk("wr_rdy_data", rd_data, 32'hDEAD_BEEF);
    chk("wr_rdy_rw", bus_rw, 0);
    chk("wr_rdy_wdata", bus_wr_data, 32'hA5A5_A5A5);
    as_ = 1'b1;
    step;
    bus_rdy_ = 1'b1; settle;
    chk("wr_done_req", bus_req_, 1);
    chk("wr_done_wdata", bus_wr_data, 0);
    chk("wr_done_rw", bus_rw, 1);
    chk("wr_as_pulses", as_cnt - as_base, 1);

    // completion while stalled: read data held in rd_buf
    addr = 30'h0000_0080; rw = 1'b1; as_ = 1'b0; bus_grnt_ = 1'b0;
    step;
    step;
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD_F00D; stall = 1'b1; settle;
    chk("st_cmp_busy", busy, 0);
    chk("st_cmp_data", rd_data, 32'h0BAD_F00D);
    step;
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("st_hold_data", rd_data, 32'h0BAD_F00D);
      chk("st_hold_busy", busy, 0);
      chk("st_hold_req", bus_req_, 1);
      step;
    end
    stall = 1'b0; as_ = 1'b1; settle;
    chk("st_last_data", rd_data, 32'h0BAD_F00D);
    step;
    chk("st_idle_data", rd_data, 0);
    chk("st_idle_busy", busy, 0);

    // flush in IDLE suppresses the access
    addr = 30'h0000_0100; as_ = 1'b0; flush = 1'b1; settle;
    chk("fl_idle_busy", busy, 0);
    chk("fl_idle_data", rd_data, 0);
    step;
    chk("fl_idle_req", bus_req_, 1);
    chk("fl_idle_busy2", busy, 0);
    // flush during REQ does not cancel the transaction
    flush = 1'b0; settle;
    chk("fl_start_busy", busy, 1);
    step;
    flush = 1'b1; settle;
    chk("fl_req_req", bus_req_, 0);
    chk("fl_req_busy", busy, 1);
    step;
    chk("fl_req_hold", bus_req_, 0);
    bus_grnt_ = 1'b0;
    step;
    bus_grnt_ = 1'b1;
    chk("fl_acc_as", bus_as_, 0);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h5555_AAAA; settle;
    chk("fl_acc_busy", busy, 0);
    chk("fl_acc_data", rd_data, 32'h5555_AAAA);
    as_ = 1'b1;
    step;
    bus_rdy_ = 1'b1; flush = 1'b0; settle;
    chk("fl_done_req", bus_req_, 1);

    // asynchronous reset in ACCESS
    addr = 30'h0000_0200; as_ = 1'b0; bus_grnt_ = 1'b0;
    step;
    step;
    bus_grnt_ = 1'b1;
    chk("ar_acc_as", bus_as_, 0);
    chk("ar_acc_addr", bus_addr, 30'h200);
    #1 reset = 1'b1;
    #1;
    chk("ar_req", bus_req_, 1);
    chk("ar_as", bus_as_, 1);
    chk("ar_busy", busy, 0);
    chk("ar_addr", bus_addr, 0);
    step;
    reset = 1'b0; as_ = 1'b1;
    step;
    addr = 30'h1800_0ABC; as_ = 1'b0; spm_rd_data = 32'h7777_0002; settle;
    chk("ar_spm_as", spm_as_, 0);
    chk("ar_spm_addr", spm_addr, 12'hABC);
    chk("ar_spm_data", rd_data, 32'h7777_0002);
    chk("ar_spm_busy", busy, 0);
    step;
    chk("ar_spm_req", bus_req_, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_if.md
Name: bus_if

Overview:
- Per-stage memory access initiator; one instance serves IF and one serves MEM.
- Decodes each CPU word address and routes it either to the SPM port it owns (spm port a or b) or to the shared system bus via request/grant arbitration.
- Sequences multi-cycle bus transactions and raises busy to stall the pipeline.
- Buffers read data when the pipeline is stalled at completion.

Parameters:
- WORD_ADDR_W, 30, CPU word address width.
- DATA_W, 32, data width.
- SPM_ADDR_W, 12, SPM word address width; low bits of addr are driven to SPM.
- SPM_AREA, 3'h3, value of addr[WORD_ADDR_W-1 -: 3] that selects SPM.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall.
- flush  in  1  pipeline flush; suppresses a new access in IDLE.
- busy  out  1  access in progress; pipeline must stall.
- addr  in  WORD_ADDR_W  CPU word address.
- as_  in  1  address strobe, active low.
- rw  in  1  1=READ, 0=WRITE.
- wr_data  in  DATA_W  write data.
- rd_data  out  DATA_W  read data to the pipeline.
- spm_addr  out  SPM_ADDR_W  SPM address, equal to addr[SPM_ADDR_W-1:0].
- spm_as_  out  1  SPM strobe, active low.
- spm_rw  out  1  SPM read/write.
- spm_wr_data  out  DATA_W  SPM write data.
- spm_rd_data  in  DATA_W  SPM read data.
- bus_req_  out  1  bus request, active low.
- bus_grnt_  in  1  bus grant, active low.
- bus_addr  out  WORD_ADDR_W  registered bus address.
- bus_as_  out  1  bus strobe, active low.
- bus_rw  out  1  registered read/write.
- bus_wr_data  out  DATA_W  registered write data.
- bus_rd_data  in  DATA_W  bus read data.
- bus_rdy_  in  1  bus ready, active low.

Behaviour:
- Reset (asynchronous, active-high) forces these values:
  - state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1 (READ).
  - bus_addr=0, bus_wr_data=0, rd_buf=0.
  - busy=0, spm_as_=1.
- Reset mid-transaction aborts immediately and releases the bus. No completion is signalled.
- spm_addr, spm_rw and spm_wr_data are always combinational pass-throughs of addr, rw and wr_data.
- SPM hit is defined as: addr top 3 bits == SPM_AREA.
- rd_data default is 0, except in the cases below.
- IDLE:
  - No access when flush=1 or as_=1: busy=0, rd_data=0.
  - SPM hit with as_=0: spm_as_=0 combinationally, rd_data=spm_rd_data, busy=0, no state change. This is a zero-stall access.
  - Non-SPM with as_=0:
    - Combinationally: busy=1.
    - Next edge: register addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data, drive bus_req_=0, go to REQ.
- REQ:
  - busy=1; hold bus_req_=0.
  - On bus_grnt_=0: next edge drives bus_as_=0 for exactly one cycle, go to ACCESS.
  - Otherwise wait indefinitely.
- ACCESS:
  - bus_as_=1; busy=1 until ready arrives.
  - On bus_rdy_=0 (same cycle):
    - busy=0 and rd_data=bus_rd_data combinationally.
    - Next edge: bus_req_=1, bus_addr/bus_rw/bus_wr_data cleared to reset values, rd_buf<=bus_rd_data.
    - If stall=1, go to STALL; else go to IDLE.
- STALL:
  - busy=0, rd_data=rd_buf.
  - Return to IDLE on the first edge with stall=0.
- flush has no effect in REQ, ACCESS or STALL. A bus transaction in flight always completes.
- stall has no effect on IDLE decoding. The driving stage holds addr/as_ while stalled.
- Write transactions return rd_data=bus_rd_data/rd_buf as-is; the consumer ignores it.
- Latency:
  - SPM access: 0 extra cycles.
  - Bus access: minimum 3 cycles from request (IDLE->REQ->ACCESS with immediate grant and ready) + arbitration wait + device wait.

Test Plan:
- SPM read: addr=30'h1800_0010, as_=0, rw=1, spm_rd_data=32'hCAFE_0001 -> same cycle spm_as_=0, spm_addr=12'h010, rd_data=32'hCAFE_0001, busy=0, bus_req_ stays 1.
- Bus read, immediate grant/ready: addr=30'h0000_0040, as_=0, rw=1; bus_grnt_=0; bus_rdy_=0 with bus_rd_data=32'h1234_5678 in ACCESS:
  - bus_req_=0 from cycle 1.
  - bus_as_=0 for exactly cycle 2 with bus_addr=30'h40.
  - busy high in cycles 0-2 and low in cycle 3 with rd_data=32'h1234_5678.
  - bus_req_=1 in cycle 4.
- Bus write with grant delayed 4 cycles and ready delayed 2 cycles, wr_data=32'hA5A5_A5A5:
  - busy stays 1 throughout.
  - bus_as_ pulses once.
  - bus_rw=0, bus_wr_data=32'hA5A5_A5A5 held stable until ready.
  - busy drops on the ready cycle.
- Stall at completion: bus read completes with stall=1 held 3 more cycles -> state STALL; rd_data=rd_buf=read value for all stalled cycles; IDLE after stall drops.
- Flush in IDLE with as_=0 non-SPM -> no bus_req_, busy=0. Flush asserted during REQ -> transaction still completes.
- Reset asserted asynchronously in ACCESS -> bus_req_=1, bus_as_=1, busy=0, bus_addr=0 before the next clock edge. After release, a fresh SPM read works.
